// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-addressed dmem without byte enables.
// Sub-word stores are built as read-modify-write; loads return extended lanes.
module lsu_dmem_master #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_is_load,
  output logic        dmem_is_store,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_store_data,
  input  logic [31:0] dmem_load_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic req_illegal;
  logic req_misaligned;
  logic req_out_of_range;
  logic req_err;
  logic req_is_sw;

  always_comb begin
    req_illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
    req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_out_of_range = |req_addr[31:ADDR_WIDTH+2];
    req_err          = req_illegal || req_misaligned || req_out_of_range;
    req_is_sw        = req_we && (req_funct3 == 3'b010);
  end

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (funct3[1:0] == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wdata;
    end else begin
      r[15:0] = wdata;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      dmem_is_load    <= 1'b0;
      dmem_is_store   <= 1'b0;
      dmem_addr       <= '0;
      dmem_store_data <= '0;
      lat_we          <= 1'b0;
      lat_funct3      <= '0;
      lat_off         <= '0;
      lat_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              dmem_addr <= {{(32-ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
              // Full-word stores go straight out; everything else reads first.
              if (req_is_sw) begin
                dmem_is_store   <= 1'b1;
                dmem_store_data <= req_wdata;
              end else begin
                dmem_is_load <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          dmem_is_load  <= 1'b0;
          dmem_is_store <= 1'b0;
          if (!lat_we) begin
            resp_rdata <= load_extract(dmem_load_data, lat_funct3, lat_off);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (lat_funct3[1:0] == 2'b10) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            dmem_store_data <= store_merge(dmem_load_data, lat_funct3, lat_off, lat_wdata);
            dmem_is_store   <= 1'b1;
            state           <= WRITE;
          end
        end
        WRITE: begin
          dmem_is_store <= 1'b0;
          resp_rdata    <= '0;
          resp_err      <= 1'b0;
          resp_valid    <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          dmem_is_load  <= 1'b0;
          dmem_is_store <= 1'b0;
          resp_valid    <= 1'b0;
          req_ready     <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
